// File: rtl/norm_shift_pkg.sv
// Shared definitions for the normalizing left shifter.
// Holds the width defaults, the FSM state type and the per-cycle step size.
// The step size depends on the NORM_SHIFT_FAST_EN macro:
// defined gives 8 bit positions per cycle, undefined gives 1.
package norm_pkg;

    localparam int NORM_WIDTH = 32;
    localparam int NORM_CNT_W = 6;

`ifdef NORM_SHIFT_FAST_EN
    localparam int STEP = 8;
`else
    localparam int STEP = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/norm_shift_if.sv
// Request/result bundle of the normalizing shifter.
// master: start, data_in, shamt_in out; busy, done, data_out, err in.
// slave:  the mirror image, used by the shifter itself.
interface norm_shift_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] shamt_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic             err;

    modport master (
        output start, data_in, shamt_in,
        input  busy, done, data_out, err
    );

    modport slave (
        input  start, data_in, shamt_in,
        output busy, done, data_out, err
    );
endinterface

// File: rtl/norm_shift_step.sv
// One cycle of the shifter datapath (norm_step), purely combinational.
// Ports: acc/rem in; acc_nxt/rem_nxt out after a step of min(rem, STEP).
module norm_step
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int CNT_W = NORM_CNT_W,
    parameter int SSTEP = STEP
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [CNT_W-1:0] rem,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [CNT_W-1:0] rem_nxt
);
    logic [CNT_W-1:0] step;

    // Clamping the step to rem is what keeps rem from underflowing.
    always_comb begin
        step    = (rem > CNT_W'(SSTEP)) ? CNT_W'(SSTEP) : rem;
        acc_nxt = acc << step;
        rem_nxt = rem - step;
    end
endmodule

// File: rtl/norm_shift.sv
// Multi-cycle normalizing left shifter with start/busy/done handshake.
// Ports: clk, rst (sync, active-high), bus (norm_shift_if.slave).
// Latency is 1 + ceil(min(n, WIDTH) / STEP); see NORM_SHIFT_FAST_EN.
module norm_shift
    import norm_pkg::*;
#(
    parameter int WIDTH = NORM_WIDTH,
    parameter int CNT_W = NORM_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    norm_shift_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             err_r_q, err_r_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] step_acc;
    logic [CNT_W-1:0] step_rem;
    logic             accept;
    logic             over;
    logic [CNT_W-1:0] clamp;

    norm_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .SSTEP (STEP)
    ) u_step (
        .acc     (acc_q),
        .rem     (rem_q),
        .acc_nxt (step_acc),
        .rem_nxt (step_rem)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        err_r_d = err_r_q;
        dout_d  = dout_q;
        err_d   = err_q;

        accept = bus.start && (state_q != SHIFT);
        over   = bus.shamt_in > CNT_W'(WIDTH);
        clamp  = over ? CNT_W'(WIDTH) : bus.shamt_in;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    acc_d   = bus.data_in;
                    rem_d   = clamp;
                    err_r_d = over;
                    if (clamp == '0) begin
                        // Zero shift: result is ready on the next edge.
                        state_d = DONE;
                        dout_d  = bus.data_in;
                        err_d   = over;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = step_acc;
                rem_d = step_rem;
                if (step_rem == '0) begin
                    // Publish on the edge that raises done.
                    state_d = DONE;
                    dout_d  = step_acc;
                    err_d   = err_r_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            err_r_q <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            err_r_q <= err_r_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.data_out = dout_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_norm_shift.sv
// Directed self-checking bench for norm_shift.
// Expected latencies follow NORM_SHIFT_FAST_EN.
module tb_norm_shift;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

`ifdef NORM_SHIFT_FAST_EN
    localparam int LAT31  = 5;
    localparam int LAT32  = 5;
    localparam int BUSY31 = 4;
    localparam int LAT30  = 5;
    localparam int IGN_C  = 1;
    localparam int IGN_D  = 2;
    localparam int RST_C  = 2;
`else
    localparam int LAT31  = 32;
    localparam int LAT32  = 33;
    localparam int BUSY31 = 31;
    localparam int LAT30  = 31;
    localparam int IGN_C  = 2;
    localparam int IGN_D  = 5;
    localparam int RST_C  = 5;
`endif

    norm_shift_if #(.WIDTH(32), .CNT_W(6)) bus ();

    norm_shift u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [31:0] d, input logic [5:0] s);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.data_in  = d;
        bus.shamt_in = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns the cycle index (start edge = 0) of done, or -1 on timeout.
    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = -1;
        busy_n = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.data_in  = '0;
        bus.shamt_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_done got %b want 0", bus.done);
        end
        tests++;
        if (bus.data_out !== 32'h0) begin
            fails++;
            $display("FAIL reset_dout got %h want 0", bus.data_out);
        end
        tests++;
        if (bus.err !== 1'b0) begin
            fails++;
            $display("FAIL reset_err got %b want 0", bus.err);
        end
        rst = 1'b0;
    endtask

    task automatic test_shift31();
        int cyc, bn;
        start_op(32'h0000_0001, 6'd31);
        wait_done(cyc, bn);
        tests++;
        if (cyc !== LAT31) begin
            fails++;
            $display("FAIL s31_lat got %0d want %0d", cyc, LAT31);
        end
        tests++;
        if (bn !== BUSY31) begin
            fails++;
            $display("FAIL s31_busy got %0d want %0d", bn, BUSY31);
        end
        tests++;
        if (bus.data_out !== 32'h8000_0000) begin
            fails++;
            $display("FAIL s31_dout got %h want 80000000", bus.data_out);
        end
        tests++;
        if (bus.err !== 1'b0) begin
            fails++;
            $display("FAIL s31_err got %b want 0", bus.err);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL s31_busy_done got %b want 0", bus.busy);
        end
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.data_out !== 32'h8000_0000) begin
            fails++;
            $display("FAIL s31_pulse got done=%b dout=%h want 0/80000000",
                     bus.done, bus.data_out);
        end
    endtask

    task automatic test_zero();
        int cyc, bn;
        start_op(32'h1234_5678, 6'd0);
        wait_done(cyc, bn);
        tests++;
        if (cyc !== 1) begin
            fails++;
            $display("FAIL z_lat got %0d want 1", cyc);
        end
        tests++;
        if (bn !== 0) begin
            fails++;
            $display("FAIL z_busy got %0d want 0", bn);
        end
        tests++;
        if (bus.data_out !== 32'h1234_5678) begin
            fails++;
            $display("FAIL z_dout got %h want 12345678", bus.data_out);
        end
    endtask

    task automatic test_overflow();
        int cyc, bn;
        start_op(32'hFFFF_FFFF, 6'd32);
        wait_done(cyc, bn);
        tests++;
        if (cyc !== LAT32) begin
            fails++;
            $display("FAIL o32_lat got %0d want %0d", cyc, LAT32);
        end
        tests++;
        if (bus.data_out !== 32'h0 || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL o32_res got %h/%b want 0/0", bus.data_out, bus.err);
        end
        start_op(32'hFFFF_FFFF, 6'd40);
        wait_done(cyc, bn);
        tests++;
        if (cyc !== LAT32) begin
            fails++;
            $display("FAIL o40_lat got %0d want %0d", cyc, LAT32);
        end
        tests++;
        if (bus.data_out !== 32'h0 || bus.err !== 1'b1) begin
            fails++;
            $display("FAIL o40_res got %h/%b want 0/1", bus.data_out, bus.err);
        end
        @(negedge clk);
        tests++;
        if (bus.err !== 1'b1) begin
            fails++;
            $display("FAIL o40_hold got %b want 1", bus.err);
        end
    endtask

    task automatic test_ignore();
        int got, extra;
        got   = -1;
        extra = 0;
        start_op(32'h0000_00F0, 6'd4);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (got < 0) got = c;
                else extra++;
            end
            bus.start = (c == IGN_C);
            if (c == IGN_C) begin
                bus.data_in  = 32'hDEAD_BEEF;
                bus.shamt_in = 6'd1;
            end
        end
        tests++;
        if (got !== IGN_D) begin
            fails++;
            $display("FAIL ign_lat got %0d want %0d", got, IGN_D);
        end
        tests++;
        if (bus.data_out !== 32'h0000_0F00) begin
            fails++;
            $display("FAIL ign_dout got %h want 00000f00", bus.data_out);
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL ign_extra got %0d want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bn;
        start_op(32'h0000_0003, 6'd30);
        wait_done(cyc, bn);
        tests++;
        if (cyc !== LAT30 || bus.data_out !== 32'hC000_0000) begin
            fails++;
            $display("FAIL b2b_first got %0d/%h want %0d/c0000000",
                     cyc, bus.data_out, LAT30);
        end
        bus.start    = 1'b1;
        bus.data_in  = 32'h0000_0001;
        bus.shamt_in = 6'd1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(cyc, bn);
        tests++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL b2b_lat got %0d want 2", cyc);
        end
        tests++;
        if (bus.data_out !== 32'h0000_0002) begin
            fails++;
            $display("FAIL b2b_dout got %h want 00000002", bus.data_out);
        end
    endtask

    task automatic test_mid_reset();
        int dn;
        dn = 0;
        start_op(32'h0000_0001, 6'd20);
        repeat (RST_C) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL mr_busy_pre got %b want 1", bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL mr_ctl got %b/%b want 0/0", bus.busy, bus.done);
        end
        tests++;
        if (bus.data_out !== 32'h0 || bus.err !== 1'b0) begin
            fails++;
            $display("FAIL mr_dout got %h/%b want 0/0", bus.data_out, bus.err);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        tests++;
        if (dn !== 0) begin
            fails++;
            $display("FAIL mr_quiet got %0d want 0", dn);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_shift31();
        test_zero();
        test_overflow();
        test_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
